// File: rtl/irq_controller.sv
// Machine-mode interrupt controller.
// Collects peripheral requests, masks them with mie, picks the lowest-index
// enabled line, raises a one-cycle trap request toward the CSR block, blocks
// nesting while a handler runs and acknowledges the served line after mret.
module irq_controller #(
  parameter int unsigned N_IRQ     = 16,
  parameter logic [15:0] EDGE_MASK = 16'h0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [31:0]      mie_i,
  input  logic             exception_i,
  input  logic             stall_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic             busy_o
);

  localparam int unsigned SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [31:0] CAUSE_BASE = 32'h8000_0010;
  localparam logic [N_IRQ-1:0] EDGE = EDGE_MASK[N_IRQ-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAKE = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   sel_q;
  logic [N_IRQ-1:0]   ret_q;
  logic [N_IRQ-1:0]   ret_next;
  logic [N_IRQ-1:0]   edge_pend;
  logic [N_IRQ-1:0]   edge_pend_next;
  logic [N_IRQ-1:0]   req_q;
  logic [N_IRQ-1:0]   pend;
  logic [N_IRQ-1:0]   en;
  logic [SEL_W-1:0]   win;
  logic               any_en;
  logic               take;

  // Only mie[16 +: N_IRQ] are interrupt enables; the rest are folded here so
  // the whole CSR image is visibly consumed.
  logic unused_mie_bits;
  assign unused_mie_bits = ^mie_i;

  // Pending/enabled vectors and fixed-priority winner (line 0 highest).
  always_comb begin
    // NOTE: every signal gets a default at the top of a comb block, so no path leaves it unassigned and no latch is inferred.
    pend   = (EDGE & edge_pend) | (~EDGE & irq_req_i);
    en     = pend & mie_i[16 +: N_IRQ];
    win    = '0;
    any_en = 1'b0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (en[k]) begin
        win    = SEL_W'(k);
        any_en = 1'b1;
      end
    end
  end

  // Trap launch condition: only from IDLE, never during stall/exception,
  // never in the ack cycle and never while reset is being applied.
  always_comb begin
    take = rst_i && (state == IDLE) && any_en && !exception_i && !stall_i
           && (ret_q == '0);
  end

  // Next-state logic of the handler FSM.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (take) state_next = TAKE;
      TAKE:    state_next = BUSY;
      BUSY:    if (mret_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: combinational trap pulse and cause, busy flag.
  always_comb begin
    irq_o       = 1'b0;
    irq_cause_o = 32'h0;
    busy_o      = 1'b0;
    unique case (state)
      IDLE: begin
        irq_o = take;
        if (take) irq_cause_o = CAUSE_BASE + 32'(win);
      end
      TAKE, BUSY: begin
        busy_o      = 1'b1;
        irq_cause_o = CAUSE_BASE + 32'(sel_q);
      end
      default: ;
    endcase
    irq_ret_o = ret_q;
  end

  // Next values of the ack pulse and the sticky edge flags.
  always_comb begin
    ret_next = '0;
    if (state == BUSY && mret_i) begin
      for (int k = 0; k < N_IRQ; k++) begin
        ret_next[k] = (sel_q == SEL_W'(k));
      end
    end
    // A fresh rising edge wins over the ack clearing the same flag.
    edge_pend_next = EDGE & ((edge_pend & ~ret_q) | (irq_req_i & ~req_q));
  end

  // State register of the handler FSM.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is sampled inside the clocked block (synchronous), so it is absent from the sensitivity list.
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state <= state_next;
    end
  end

  // Winner index, ack pulse, edge flags and previous request sample.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      sel_q     <= '0;
      ret_q     <= '0;
      edge_pend <= '0;
      req_q     <= '0;
    end else begin
      if (take) sel_q <= win;
      ret_q     <= ret_next;
      edge_pend <= edge_pend_next;
      req_q     <= irq_req_i;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed, table-driven bench for irq_controller. Line 1 is edge-triggered,
// every other line is level-sensitive. Inputs change on the falling edge and
// outputs are sampled 1 ns later, away from the rising edge.
module tb_irq_controller;

  localparam logic [31:0] C10 = 32'h8000_0010;
  localparam logic [31:0] C11 = 32'h8000_0011;
  localparam logic [31:0] C12 = 32'h8000_0012;
  localparam logic [31:0] C13 = 32'h8000_0013;
  localparam logic [31:0] C14 = 32'h8000_0014;
  localparam logic [31:0] C15 = 32'h8000_0015;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [31:0] mie;
    logic        exc;
    logic        stall;
    logic        mret;
    logic        irq;
    logic [31:0] cause;
    logic [15:0] ret;
    logic        busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] irq_req_i;
  logic [31:0] mie_i;
  logic        exception_i;
  logic        stall_i;
  logic        mret_i;
  logic        irq_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ret_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  irq_controller #(
    .N_IRQ     (16),
    .EDGE_MASK (16'h0002)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .irq_req_i   (irq_req_i),
    .mie_i       (mie_i),
    .exception_i (exception_i),
    .stall_i     (stall_i),
    .mret_i      (mret_i),
    .irq_o       (irq_o),
    .irq_cause_o (irq_cause_o),
    .irq_ret_o   (irq_ret_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [15:0] req, input logic [31:0] mie,
                     input logic exc, input logic stall, input logic mret,
                     input logic irq, input logic [31:0] cause,
                     input logic [15:0] ret, input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.mie = mie; v.exc = exc; v.stall = stall;
    v.mret = mret; v.irq = irq; v.cause = cause; v.ret = ret; v.busy = busy;
    vecs.push_back(v);
  endtask

  // One cycle: drive on the falling edge, settle, leave sampling to caller.
  task automatic step(input logic rst, input logic [15:0] req, input logic [31:0] mie,
                      input logic exc, input logic stall, input logic mret);
    @(negedge clk);
    rst_i = rst; irq_req_i = req; mie_i = mie;
    exception_i = exc; stall_i = stall; mret_i = mret;
    #1;
  endtask

  task automatic expect_all(input int idx, input logic irq, input logic [31:0] cause,
                            input logic [15:0] ret, input logic busy);
    check("irq_o", idx, {31'h0, irq_o}, {31'h0, irq});
    check("irq_cause_o", idx, irq_cause_o, cause);
    check("irq_ret_o", idx, {16'h0, irq_ret_o}, {16'h0, ret});
    check("busy_o", idx, {31'h0, busy_o}, {31'h0, busy});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; irq_req_i = '0; mie_i = '0;
    exception_i = 1'b0; stall_i = 1'b0; mret_i = 1'b0;
    repeat (2) @(posedge clk);

    // rst, req, mie, exc, stall, mret | irq, cause, ret, busy
    // Reset state, then a basic level trap on line 0 and its ack.
    add(0, 16'h0000, 32'h0000_0000, 0, 0, 0, 0, 32'h0, 16'h0000, 0);
    add(1, 16'h0001, 32'h0001_0000, 0, 0, 0, 1, C10,   16'h0000, 0);
    add(1, 16'h0001, 32'h0001_0000, 0, 0, 0, 0, C10,   16'h0000, 1);
    add(1, 16'h0001, 32'h0001_0000, 0, 0, 0, 0, C10,   16'h0000, 1);
    add(1, 16'h0001, 32'h0001_0000, 0, 0, 1, 0, C10,   16'h0000, 1);
    // Ack cycle suppresses a trap even though line 0 is still high.
    add(1, 16'h0001, 32'h0001_0000, 0, 0, 0, 0, 32'h0, 16'h0001, 0);
    add(1, 16'h0001, 32'h0001_0000, 0, 0, 0, 1, C10,   16'h0000, 0);
    add(1, 16'h0000, 32'h0001_0000, 0, 0, 0, 0, C10,   16'h0000, 1);
    add(1, 16'h0000, 32'h0001_0000, 0, 0, 1, 0, C10,   16'h0000, 1);
    add(1, 16'h0000, 32'h0001_0000, 0, 0, 0, 0, 32'h0, 16'h0001, 0);
    add(1, 16'h0000, 32'h0001_0000, 0, 0, 0, 0, 32'h0, 16'h0000, 0);
    // Priority: lines 3 and 5, line 3 first; then line 5 after line 3 drops.
    add(1, 16'h0028, 32'h0028_0000, 0, 0, 0, 1, C13,   16'h0000, 0);
    add(1, 16'h0028, 32'h0028_0000, 0, 0, 0, 0, C13,   16'h0000, 1);
    add(1, 16'h0028, 32'h0028_0000, 0, 0, 1, 0, C13,   16'h0000, 1);
    add(1, 16'h0020, 32'h0028_0000, 0, 0, 0, 0, 32'h0, 16'h0008, 0);
    add(1, 16'h0020, 32'h0028_0000, 0, 0, 0, 1, C15,   16'h0000, 0);
    add(1, 16'h0020, 32'h0028_0000, 0, 0, 0, 0, C15,   16'h0000, 1);
    add(1, 16'h0020, 32'h0028_0000, 0, 0, 1, 0, C15,   16'h0000, 1);
    add(1, 16'h0000, 32'h0028_0000, 0, 0, 0, 0, 32'h0, 16'h0020, 0);
    // mret in IDLE is ignored: no ack follows.
    add(1, 16'h0000, 32'h0028_0000, 0, 0, 1, 0, 32'h0, 16'h0000, 0);
    add(1, 16'h0000, 32'h0028_0000, 0, 0, 0, 0, 32'h0, 16'h0000, 0);
    // Masking: line 2 pending but disabled for 10 cycles, then enabled.
    for (int i = 0; i < 10; i++)
      add(1, 16'h0004, 32'h0000_0000, 0, 0, 0, 0, 32'h0, 16'h0000, 0);
    add(1, 16'h0004, 32'h0004_0000, 0, 0, 0, 1, C12,   16'h0000, 0);
    // mie cleared during the handler: still busy, still acked.
    add(1, 16'h0004, 32'h0000_0000, 0, 0, 0, 0, C12,   16'h0000, 1);
    add(1, 16'h0004, 32'h0000_0000, 0, 0, 1, 0, C12,   16'h0000, 1);
    add(1, 16'h0000, 32'h0000_0000, 0, 0, 0, 0, 32'h0, 16'h0004, 0);
    // Blocking by stall / exception, then trap on the first clear cycle.
    add(1, 16'h0004, 32'h0005_0000, 0, 1, 0, 0, 32'h0, 16'h0000, 0);
    add(1, 16'h0004, 32'h0005_0000, 0, 1, 0, 0, 32'h0, 16'h0000, 0);
    add(1, 16'h0004, 32'h0005_0000, 1, 0, 0, 0, 32'h0, 16'h0000, 0);
    add(1, 16'h0004, 32'h0005_0000, 1, 1, 0, 0, 32'h0, 16'h0000, 0);
    add(1, 16'h0004, 32'h0005_0000, 0, 0, 0, 1, C12,   16'h0000, 0);
    // Higher-priority line 0 arrives while busy: no nesting.
    add(1, 16'h0000, 32'h0005_0000, 0, 0, 0, 0, C12,   16'h0000, 1);
    add(1, 16'h0001, 32'h0005_0000, 0, 0, 0, 0, C12,   16'h0000, 1);
    add(1, 16'h0001, 32'h0005_0000, 0, 0, 0, 0, C12,   16'h0000, 1);
    add(1, 16'h0001, 32'h0005_0000, 0, 0, 1, 0, C12,   16'h0000, 1);
    add(1, 16'h0001, 32'h0005_0000, 0, 0, 0, 0, 32'h0, 16'h0004, 0);
    add(1, 16'h0001, 32'h0005_0000, 0, 0, 0, 1, C10,   16'h0000, 0);
    // mret during TAKE is ignored; the real mret comes later in BUSY.
    add(1, 16'h0000, 32'h0005_0000, 0, 0, 1, 0, C10,   16'h0000, 1);
    add(1, 16'h0000, 32'h0005_0000, 0, 0, 0, 0, C10,   16'h0000, 1);
    add(1, 16'h0000, 32'h0005_0000, 0, 0, 1, 0, C10,   16'h0000, 1);
    add(1, 16'h0000, 32'h0005_0000, 0, 0, 0, 0, 32'h0, 16'h0001, 0);
    // Edge line 1 pulsed while serving level line 4.
    add(1, 16'h0010, 32'h0012_0000, 0, 0, 0, 1, C14,   16'h0000, 0);
    add(1, 16'h0012, 32'h0012_0000, 0, 0, 0, 0, C14,   16'h0000, 1);
    add(1, 16'h0010, 32'h0012_0000, 0, 0, 0, 0, C14,   16'h0000, 1);
    add(1, 16'h0010, 32'h0012_0000, 0, 0, 1, 0, C14,   16'h0000, 1);
    add(1, 16'h0000, 32'h0012_0000, 0, 0, 0, 0, 32'h0, 16'h0010, 0);
    add(1, 16'h0000, 32'h0012_0000, 0, 0, 0, 1, C11,   16'h0000, 0);
    add(1, 16'h0000, 32'h0012_0000, 0, 0, 0, 0, C11,   16'h0000, 1);
    add(1, 16'h0000, 32'h0012_0000, 0, 0, 1, 0, C11,   16'h0000, 1);
    add(1, 16'h0000, 32'h0012_0000, 0, 0, 0, 0, 32'h0, 16'h0002, 0);
    add(1, 16'h0000, 32'h0012_0000, 0, 0, 0, 0, 32'h0, 16'h0000, 0);
    add(1, 16'h0000, 32'h0012_0000, 0, 0, 0, 0, 32'h0, 16'h0000, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].mie,
           vecs[i].exc, vecs[i].stall, vecs[i].mret);
      expect_all(i, vecs[i].irq, vecs[i].cause, vecs[i].ret, vecs[i].busy);
    end

    // Reset in the middle of a handler, with an edge flag latched meanwhile.
    step(1, 16'h0008, 32'h000A_0000, 0, 0, 0);
    expect_all(1000, 1'b1, C13, 16'h0000, 1'b0);
    step(1, 16'h0002, 32'h000A_0000, 0, 0, 0);
    expect_all(1001, 1'b0, C13, 16'h0000, 1'b1);
    step(1, 16'h0000, 32'h000A_0000, 0, 0, 0);
    expect_all(1002, 1'b0, C13, 16'h0000, 1'b1);
    step(0, 16'h0000, 32'h000A_0000, 0, 0, 1);
    check("irq_o", 1003, {31'h0, irq_o}, 32'h0);
    check("irq_ret_o", 1003, {16'h0, irq_ret_o}, 32'h0);
    // Stale mret after reset: ignored; cleared edge flag raises no trap.
    step(1, 16'h0000, 32'h000A_0000, 0, 0, 1);
    expect_all(1004, 1'b0, 32'h0, 16'h0000, 1'b0);
    step(1, 16'h0000, 32'h000A_0000, 0, 0, 0);
    expect_all(1005, 1'b0, 32'h0, 16'h0000, 1'b0);
    step(1, 16'h0008, 32'h000A_0000, 0, 0, 0);
    expect_all(1006, 1'b1, C13, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Machine-mode interrupt controller for the RISC-V practicum core; it sits directly upstream of the CSR controller. It collects peripheral interrupt requests, masks them with `mie`, selects one by fixed priority and raises a single-cycle trap request. That request drives the CSR controller's `trap_i`/`mcause_i`, and the `mepc`/`mtvec` update happens there. It tracks whether a handler is in progress, blocks nesting, and acknowledges the served peripheral when the handler executes `mret`.

## Interface
- `N_IRQ`, 16 — number of interrupt lines, 1..16; line k maps to `mie` bit 16+k.
- `EDGE_MASK`, 16'h0000 — bit k = 1 makes line k edge-triggered (rising edge latched); 0 = level-sensitive.
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  synchronous, active-low reset (sampled on rising edge of `clk_i`, 0 = reset).
- `irq_req_i`  in  N_IRQ  peripheral requests.
- `mie_i`  in  32  `mie_o` from the CSR controller; only bits [16+N_IRQ-1:16] are used.
- `exception_i`  in  1  synchronous exception (illegal instruction) in the current cycle.
- `stall_i`  in  1  core stalled (LSU busy); no trap may be launched while high.
- `mret_i`  in  1  `mret` executing this cycle (qualified by core as not stalled).
- `irq_o`  out  1  trap request to the core/CSR `trap_i`.
- `irq_cause_o`  out  32  `mcause` value for the trap.
- `irq_ret_o`  out  N_IRQ  one-hot acknowledge to the served peripheral.
- `busy_o`  out  1  handler in progress (debug/visibility).

## Operation
- Pending vector: `pend[k]` = `irq_req_i[k]` for level lines. For edge lines it is the sticky flag `edge_pend[k]`, which is set when `irq_req_i[k]` is 1 now and was 0 last cycle. It is cleared only by `irq_ret_o[k]`. If set and clear happen in the same cycle, set wins.
- Enabled vector: `en[k] = pend[k] & mie_i[16+k]`.
- Selection: the lowest index k with `en[k]=1` wins (line 0 has the highest priority).
- States:
  - IDLE → TAKE when `en != 0`, `exception_i=0` and `stall_i=0`.
  - TAKE → BUSY unconditionally.
  - BUSY → IDLE on `mret_i=1`.
  - TAKE exists only to register the winner; no new selection happens in TAKE or BUSY (no nesting).
- `irq_o` is combinational. It is 1 exactly in the IDLE cycle where the IDLE→TAKE condition holds, so the core traps on that instruction.
- `irq_cause_o`:
  - Combinational `32'h8000_0010 + k` while `irq_o=1`.
  - Holds the registered winner's cause in TAKE and BUSY.
  - Otherwise 0.
- A winner index register `sel_q` is loaded in the IDLE→TAKE cycle.
- `irq_ret_o[sel_q]` pulses for one cycle, in the cycle after `mret_i` is sampled in BUSY (registered). This is the first IDLE cycle.
- An exception has priority over an interrupt: with `exception_i=1`, `irq_o=0` and the request stays pending.
- `mret_i` in IDLE or TAKE is ignored: no ack and no state change.
- A line whose mie bit is cleared during BUSY does not affect the in-progress handler; its ack is still issued on `mret`.

## Timing
- Reset values: state IDLE, `sel_q=0`, `edge_pend=0`, `irq_o=0`, `irq_cause_o=0`, `irq_ret_o=0`, `busy_o=0`. Synchronous reset overrides every other event in that cycle.
- Request to trap latency: 0 cycles from the sampled request cycle when IDLE and not stalled/excepted. An edge line adds 1 cycle for the latch.
- `busy_o=1` in TAKE and BUSY.
- Minimum gap between two `irq_o` pulses is 3 cycles: trap, TAKE, and the BUSY cycle with `mret`. `irq_o` is forced to 0 in the ack cycle, so the next trap can come no earlier than 1 cycle after `irq_ret_o`. This gives level-sensitive peripherals time to drop the request.
- `irq_o` is never high for two consecutive cycles.
- Reset mid-handler: the controller returns to IDLE with no ack issued and edge pending flags cleared.

## Test plan
- After reset (`rst_i=0` for 2 cycles): all outputs 0. Then `mie_i=32'h0001_0000` and level `irq_req_i[0]=1` → `irq_o=1` with `irq_cause_o=32'h8000_0010` in the same cycle. `busy_o=1` for the following cycles. `mret_i` pulse → `irq_ret_o=16'h0001` one cycle later, then `busy_o=0`.
- Priority: `irq_req_i=16'h0028`, `mie_i=32'h0028_0000` → cause `32'h8000_0013`. After `mret` and ack, line 3 drops and line 5 is still high → next trap has cause `32'h8000_0015`.
- Masking: `irq_req_i[2]=1` with `mie_i=0` for 10 cycles → `irq_o` stays 0. Set `mie_i[18]` → `irq_o` is 1 in that cycle.
- Blocking: hold `stall_i=1` or `exception_i=1` with an enabled request → `irq_o=0`. Release → trap on the first clear cycle. A new request on line 0 during BUSY → no `irq_o` until after the ack.
- Edge mode with `EDGE_MASK=16'h0002`: pulse `irq_req_i[1]` for 1 cycle while BUSY on line 4 → pending is latched. After the line-4 ack, the trap has cause `32'h8000_0011`. After the line-1 `mret`, `irq_ret_o=16'h0002` and no repeat trap follows.
- Reset mid-handler: assert `rst_i=0` in BUSY → next cycle IDLE, `irq_ret_o=0`, `busy_o=0`. A stale `mret_i` afterwards is ignored.
